// File: rtl/dm_cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache.
// Holds the controller state encoding and the default width constants
// used by dm_cache and dm_cache_array.
package dm_cache_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned INDEX_W_DEF = 2;

    typedef enum logic [2:0] {
        StIdle,
        StMemRd,
        StMemWait,
        StResp,
        StMemWr,
        StWrResp
    } state_t;

endpackage

// File: rtl/dm_cache_array.sv
// Storage for dm_cache: one data word, one tag and one valid bit per line.
// Ports:
//   clk, rst_n            clock, async active-low reset (clears valid bits only)
//   rd_index              async read index -> rd_data, rd_tag, rd_valid
//   wr_en, wr_index,
//   wr_data, wr_tag       sync write port; a write also sets the line valid
module dm_cache_array #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned INDEX_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index,
    output logic [DATA_W-1:0]  rd_data,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [TAG_W-1:0]   wr_tag
);

    localparam int unsigned LINES = 1 << INDEX_W;

    logic [DATA_W-1:0] data_mem [LINES];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid_q;

    // Data and tags are deliberately left unreset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_index] <= wr_data;
            tag_mem[wr_index]  <= wr_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    assign rd_data  = data_mem[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-through, write-allocate cache with one word per line.
// CPU side: req_valid/req_ready request port, resp_valid one-cycle response.
// Memory side: mem_req_valid/mem_req_ready request, mem_rvalid read return.
// Optional macro CACHE_STATS_EN adds saturating 16-bit hit_count/miss_count
// outputs that count completed responses by resp_hit.
module dm_cache
    import dm_cache_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned INDEX_W = INDEX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W;

    state_t             state;
    logic               hit_q;
    logic               accept;
    logic               hit;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [DATA_W-1:0]  rd_data;
    logic [TAG_W-1:0]   rd_tag;
    logic               rd_valid;
    logic               wr_en;
    logic [INDEX_W-1:0] wr_index;
    logic [DATA_W-1:0]  wr_data;
    logic [TAG_W-1:0]   wr_tag;

    assign req_ready = (state == StIdle);
    assign accept    = req_valid && req_ready;
    assign req_index = req_addr[INDEX_W-1:0];
    assign req_tag   = req_addr[ADDR_W-1:INDEX_W];
    assign hit       = rd_valid && (rd_tag == req_tag);

    // Two writers share the array port: a CPU write in IDLE (allocate) and a
    // refill in MEM_WAIT. mem_addr still holds the registered miss address.
    always_comb begin
        wr_en    = 1'b0;
        wr_index = req_index;
        wr_data  = req_wdata;
        wr_tag   = req_tag;
        if (state == StIdle && accept && req_we) begin
            wr_en = 1'b1;
        end else if (state == StMemWait && mem_rvalid) begin
            wr_en    = 1'b1;
            wr_index = mem_addr[INDEX_W-1:0];
            wr_data  = mem_rdata;
            wr_tag   = mem_addr[ADDR_W-1:INDEX_W];
        end
    end

    dm_cache_array #(
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W),
        .INDEX_W (INDEX_W)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (req_index),
        .rd_data  (rd_data),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_data  (wr_data),
        .wr_tag   (wr_tag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            hit_q         <= 1'b0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_hit      <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        if (req_we) begin
                            state         <= StMemWr;
                            hit_q         <= hit;
                            mem_req_valid <= 1'b1;
                            mem_we        <= 1'b1;
                            mem_addr      <= req_addr;
                            mem_wdata     <= req_wdata;
                        end else if (hit) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= rd_data;
                            resp_hit   <= 1'b1;
                        end else begin
                            state         <= StMemRd;
                            mem_req_valid <= 1'b1;
                            mem_we        <= 1'b0;
                            mem_addr      <= req_addr;
                        end
                    end
                end
                StMemRd: begin
                    if (mem_req_ready) begin
                        state         <= StMemWait;
                        mem_req_valid <= 1'b0;
                    end
                end
                StMemWait: begin
                    // The response is raised here so it is visible during RESP.
                    if (mem_rvalid) begin
                        state      <= StResp;
                        resp_valid <= 1'b1;
                        resp_rdata <= mem_rdata;
                        resp_hit   <= 1'b0;
                    end
                end
                StMemWr: begin
                    if (mem_req_ready) begin
                        state         <= StWrResp;
                        mem_req_valid <= 1'b0;
                        resp_valid    <= 1'b1;
                        resp_hit      <= hit_q;
                    end
                end
                StResp:   state <= StIdle;
                StWrResp: state <= StIdle;
                default:  state <= StIdle;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (resp_valid) begin
            if (resp_hit) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache.sv
// Directed self-checking bench for dm_cache (default 8-bit data/address,
// 4 lines). Inputs change and outputs are sampled 1 time unit after the
// rising edge. Define CACHE_STATS_EN to also check the statistics counters.
module tb_dm_cache;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic       resp_hit;
    logic       mem_req_valid;
    logic       mem_req_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_rvalid;
    logic [7:0] mem_rdata;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int num_checks = 0;
    int num_fails  = 0;

    dm_cache dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_hit      (resp_hit),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one accept edge.
    task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         input string tag);
        check({tag, "_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        step();
        req_valid = 1'b0;
    endtask

    // Services a read miss just accepted: accept at once, data one cycle later.
    task automatic read_miss(input logic [7:0] addr, input logic [7:0] data, input string tag);
        issue(1'b0, addr, 8'h00, tag);
        check({tag, "_mreq"}, mem_req_valid, 1);
        check({tag, "_mwe"}, mem_we, 0);
        check({tag, "_maddr"}, mem_addr, addr);
        check({tag, "_noresp"}, resp_valid, 0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check({tag, "_mreq_drop"}, mem_req_valid, 0);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        step();
        mem_rvalid = 1'b0;
        check({tag, "_rvalid"}, resp_valid, 1);
        check({tag, "_rdata"}, resp_rdata, data);
        check({tag, "_hit"}, resp_hit, 0);
        step();
        check({tag, "_pulse"}, resp_valid, 0);
        check({tag, "_idle"}, req_ready, 1);
    endtask

    task automatic read_hit(input logic [7:0] addr, input logic [7:0] data, input string tag);
        issue(1'b0, addr, 8'h00, tag);
        check({tag, "_rvalid"}, resp_valid, 1);
        check({tag, "_rdata"}, resp_rdata, data);
        check({tag, "_hit"}, resp_hit, 1);
        check({tag, "_nomreq"}, mem_req_valid, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_resp", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_mreq", mem_req_valid, 0);
        check("rst_maddr", mem_addr, 0);
        check("rst_mwe", mem_we, 0);
        step();
        rst_n = 1'b1;
        step();

        // Cold miss, then a hit on the same address.
        read_miss(8'h05, 8'hAA, "miss05");
        read_hit(8'h05, 8'hAA, "hit05");
        step();
        check("hit05_pulse", resp_valid, 0);

        // Write 09 (index 1, evicts 05) with memory stalled for 3 cycles.
        issue(1'b1, 8'h09, 8'h3C, "wr09");
        for (int i = 0; i < 3; i++) begin
            check("wr09_mreq", mem_req_valid, 1);
            check("wr09_mwe", mem_we, 1);
            check("wr09_maddr", mem_addr, 8'h09);
            check("wr09_mwdata", mem_wdata, 8'h3C);
            check("wr09_noresp", resp_valid, 0);
            step();
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("wr09_resp", resp_valid, 1);
        check("wr09_hit", resp_hit, 0);
        check("wr09_mreq_drop", mem_req_valid, 0);
        step();
        read_hit(8'h09, 8'h3C, "rd09");

        // Write hit updates the line and reports hit.
        step();
        issue(1'b1, 8'h09, 8'h5A, "wr09b");
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("wr09b_resp", resp_valid, 1);
        check("wr09b_hit", resp_hit, 1);
        step();
        read_hit(8'h09, 8'h5A, "rd09b");
        step();

        // Index aliasing: 05 and 01 both map to index 1.
        read_miss(8'h05, 8'hAA, "remiss05");
        read_miss(8'h01, 8'h11, "miss01");
        read_miss(8'h05, 8'hAA, "evict05");
        read_hit(8'h05, 8'hAA, "rehit05");
        step();

        // Reset in MEM_RD drops the memory request immediately.
        issue(1'b0, 8'h0E, 8'h00, "rstrd");
        check("rstrd_mreq", mem_req_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rstrd_mreq_drop", mem_req_valid, 0);
        #2;
        rst_n = 1'b1;
        step();

        // Reset in MEM_WAIT; late read data is ignored, lines are invalid.
        issue(1'b0, 8'h0E, 8'h00, "rstwait");
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstwait_ready", req_ready, 1);
        check("rstwait_resp", resp_valid, 0);
        #2;
        rst_n = 1'b1;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 8'h77;
        step();
        mem_rvalid = 1'b0;
        check("stray_rvalid_resp", resp_valid, 0);
        check("stray_rvalid_ready", req_ready, 1);
        check("stray_rvalid_mreq", mem_req_valid, 0);
        read_miss(8'h05, 8'hBB, "postrst05");

        // miss, hit, hit (back to back), miss.
        apply_reset();
        read_miss(8'h20, 8'hC3, "st_miss20");
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h20;
        step();
        check("b2b_first_resp", resp_valid, 1);
        check("b2b_first_data", resp_rdata, 8'hC3);
        check("b2b_first_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        check("b2b_second_resp", resp_valid, 1);
        check("b2b_second_hit", resp_hit, 1);
        step();
        read_miss(8'h24, 8'h5E, "st_miss24");
`ifdef CACHE_STATS_EN
        check("hit_count", hit_count, 2);
        check("miss_count", miss_count, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
